lsu_mem_master: RTL and testbench

- Load/store unit: the initiator side of the processor's data-memory interface.
- Takes a load/store request from the execute stage and holds the core stalled while the access is in flight.
- Drives address, size, write-enable and lane-replicated write data to the data memory, then captures the returned word and extracts and extends the addressed byte or halfword.
- Sits between the core datapath and the data memory, which has a registered write and a combinational read.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_mem_master_if.sv | 13 +
 rtl/lsu_load_extend.sv | 27 ++
 rtl/lsu_mem_master.sv | 127 ++++++++++++
 tb/tb_lsu_mem_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the alignment rule used by the optional misalignment trap.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Undefined sizes behave as word accesses, so they need a clean 4-byte address.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         LSU_B, LSU_BU: mis = 1'b0;
         LSU_H, LSU_HU: mis = addr_lo[0];
         default:       mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// The memory writes on the clock edge and returns rd_i combinationally.
interface lsu_mem_master_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [2:0]  mem_size_o;
   logic [31:0] a_o;
   logic [31:0] wd_o;
   logic [31:0] rd_i;

   modport master (output mem_req_o, mem_we_o, mem_size_o, a_o, wd_o, input rd_i);
   modport slave  (input mem_req_o, mem_we_o, mem_size_o, a_o, wd_o, output rd_i);
endinterface

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it; kept standalone so a cache can reuse it.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rd_i,
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_i[{addr_lo, 3'b000} +: 8];
      half_sel = rd_i[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
         LSU_BU:  result = {24'h000000, byte_sel};
         LSU_H:   result = {{16{half_sel[15]}}, half_sel};
         LSU_HU:  result = {16'h0000, half_sel};
         default: result = rd_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory initiator: stalls the core for MEM_LATENCY+1 cycles per access.
// Optional build macro LSU_MISALIGN_TRAP_EN adds lsu_misalign_o and skips misaligned accesses.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned XLEN        = 32
)
(
   input  logic            clk_i,
   input  logic            reset,
   input  logic            lsu_req_i,
   input  logic            lsu_we_i,
   input  logic [2:0]      lsu_size_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   output logic            lsu_stall_o,
   output logic [XLEN-1:0] lsu_rdata_o,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic            lsu_misalign_o,
`endif
   lsu_mem_master_if.master mem
);

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   lsu_state_e  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] addr_reg;
   logic [2:0]  size_reg;
   logic        we_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata_reg;
   logic [31:0] load_ext;
   logic [31:0] wd_lanes;
   logic        load_done;
   logic        req_bad;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_reg;
   assign req_bad = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
   assign req_bad = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (lsu_req_i) begin
               state_next = req_bad ? DONE : WAIT;
               cnt_next   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               state_next = DONE;
               load_done  = !we_reg;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         addr_reg  <= 32'd0;
         size_reg  <= 3'd0;
         we_reg    <= 1'b0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && lsu_req_i) begin
            addr_reg  <= lsu_addr_i;
            size_reg  <= lsu_size_i;
            we_reg    <= lsu_we_i;
            wdata_reg <= lsu_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_reg <= req_bad;
`endif
         end
         if (load_done) begin
            rdata_reg <= load_ext;
         end
      end
   end

   lsu_load_extend u_load_extend (
      .rd_i    (mem.rd_i),
      .size    (size_reg),
      .addr_lo (addr_reg[1:0]),
      .result  (load_ext)
   );

   // Each byte lane carries the store byte, the matching half of the store
   // halfword, or its own byte of the word; undefined sizes fall to word.
   for (genvar gi = 0; gi < 4; gi++) begin : g_wd_lane
      assign wd_lanes[gi*8 +: 8] = (size_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                   (size_reg[1:0] == 2'b01) ? wdata_reg[(gi%2)*8 +: 8] :
                                                              wdata_reg[gi*8 +: 8];
   end

   assign lsu_stall_o    = (state_reg == IDLE && lsu_req_i) || (state_reg == WAIT);
   assign lsu_rdata_o    = rdata_reg;
   assign mem.mem_req_o  = (state_reg == WAIT);
   assign mem.mem_we_o   = (state_reg == WAIT) && we_reg;
   assign mem.mem_size_o = size_reg;
   assign mem.a_o        = {addr_reg[31:2], 2'b00};
   assign mem.wd_o       = wd_lanes;

`ifdef LSU_MISALIGN_TRAP_EN
   assign lsu_misalign_o = (state_reg == DONE) && misalign_reg;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a vector table on an L=1 instance plus
// hand-written latency/reset sequences on an L=3 instance.
module tb_lsu_mem_master;
   import lsu_pkg::*;

   typedef struct {
      logic        we;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_word;
      logic [31:0] exp_a;
      logic [31:0] exp_wd;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req, we;
   logic [2:0]  sz;
   logic [31:0] addr, wdata, rdata;
   logic        stall;
   logic        rst3, req3, we3;
   logic [2:0]  sz3;
   logic [31:0] addr3, wdata3, rdata3, rd3;
   logic        stall3;
   logic        mis1, mis3;

   logic [31:0] mem [16];
   vec_t        vecs [15];
   int          n_applied = 0;
   int          n_fail = 0;

   lsu_mem_master_if bus1 ();
   lsu_mem_master_if bus3 ();
   assign bus1.rd_i = mem[bus1.a_o[5:2]];
   assign bus3.rd_i = rd3;

`ifndef LSU_MISALIGN_TRAP_EN
   assign mis1 = 1'b0;
   assign mis3 = 1'b0;
`endif

   lsu_mem_master #(.MEM_LATENCY(1), .XLEN(32)) u_dut1 (
      .clk_i(clk), .reset(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(sz),
      .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_stall_o(stall), .lsu_rdata_o(rdata),
`ifdef LSU_MISALIGN_TRAP_EN
      .lsu_misalign_o(mis1),
`endif
      .mem(bus1)
   );

   lsu_mem_master #(.MEM_LATENCY(3), .XLEN(32)) u_dut3 (
      .clk_i(clk), .reset(rst3), .lsu_req_i(req3), .lsu_we_i(we3), .lsu_size_i(sz3),
      .lsu_addr_i(addr3), .lsu_wdata_i(wdata3), .lsu_stall_o(stall3), .lsu_rdata_o(rdata3),
`ifdef LSU_MISALIGN_TRAP_EN
      .lsu_misalign_o(mis3),
`endif
      .mem(bus3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, want %08h", name, act, exp);
      end
   endtask

   // One access on the L=1 instance; returns stall length, strobe count and bus snapshot.
   task automatic run1(input vec_t v, output int n_stall, output int n_req,
                       output logic [31:0] a_s, output logic [31:0] wd_s,
                       output logic [2:0] sz_s, output logic we_s,
                       output logic [31:0] rd_s, output logic mis_s);
      logic        wr_pend;
      logic [31:0] wr_data;
      logic [3:0]  wr_idx;
      n_stall = 0; n_req = 0; a_s = '0; wd_s = '0; sz_s = '0; we_s = 1'b0;
      wr_data = '0; wr_idx = '0;
      if (!v.we) mem[v.addr[5:2]] = v.mem_word;
      @(negedge clk);
      req = 1'b1; we = v.we; sz = v.sz; addr = v.addr; wdata = v.wdata;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (!stall) break;
         n_stall++;
         wr_pend = 1'b0;
         if (bus1.mem_req_o) begin
            n_req++;
            a_s = bus1.a_o; wd_s = bus1.wd_o; sz_s = bus1.mem_size_o; we_s = bus1.mem_we_o;
            wr_pend = bus1.mem_we_o && (bus1.mem_size_o == LSU_W);
            wr_data = bus1.wd_o; wr_idx = bus1.a_o[5:2];
         end
         @(posedge clk); #1;
         if (wr_pend) mem[wr_idx] = wr_data;
      end
      req = 1'b0;
      rd_s = rdata;
      mis_s = mis1;
      @(posedge clk); #1;
   endtask

   initial begin
      int          ns, nr;
      logic [31:0] a_s, wd_s, rd_s;
      logic [2:0]  sz_s;
      logic        we_s, mis_s;
      vec_t        v;

      vecs[0]  = '{1'b1, LSU_W,  32'h66000010, 32'hDEADBEEF, 32'h0,        32'h66000010, 32'hDEADBEEF, 32'h00000000};
      vecs[1]  = '{1'b0, LSU_B,  32'h66000013, 32'h0,        32'h80FF0011, 32'h66000010, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{1'b0, LSU_BU, 32'h66000013, 32'h0,        32'h80FF0011, 32'h66000010, 32'h0,        32'h00000080};
      vecs[3]  = '{1'b0, LSU_H,  32'h66000002, 32'h0,        32'h80011234, 32'h66000000, 32'h0,        32'hFFFF8001};
      vecs[4]  = '{1'b0, LSU_HU, 32'h66000002, 32'h0,        32'h80011234, 32'h66000000, 32'h0,        32'h00008001};
      vecs[5]  = '{1'b1, LSU_B,  32'h66000001, 32'h000000A5, 32'h0,        32'h66000000, 32'hA5A5A5A5, 32'h00008001};
      vecs[6]  = '{1'b1, LSU_H,  32'h66000006, 32'h1234ABCD, 32'h0,        32'h66000004, 32'hABCDABCD, 32'h00008001};
      vecs[7]  = '{1'b0, LSU_B,  32'h66000010, 32'h0,        32'h123456F7, 32'h66000010, 32'h0,        32'hFFFFFFF7};
      vecs[8]  = '{1'b0, LSU_H,  32'h66000004, 32'h0,        32'h00017FFE, 32'h66000004, 32'h0,        32'h00007FFE};
      vecs[9]  = '{1'b0, LSU_W,  32'h66000008, 32'h0,        32'hCAFEBABE, 32'h66000008, 32'h0,        32'hCAFEBABE};
      vecs[10] = '{1'b0, 3'b011, 32'h6600000C, 32'h0,        32'h89ABCDEF, 32'h6600000C, 32'h0,        32'h89ABCDEF};
      vecs[11] = '{1'b1, LSU_BU, 32'h66000003, 32'h5A5A5A5A, 32'h0,        32'h66000000, 32'h5A5A5A5A, 32'h89ABCDEF};
      vecs[12] = '{1'b0, LSU_BU, 32'h66000012, 32'h0,        32'h80FF0011, 32'h66000010, 32'h0,        32'h000000FF};
      vecs[13] = '{1'b0, LSU_B,  32'h66000011, 32'h0,        32'h80FF0011, 32'h66000010, 32'h0,        32'h00000000};
      vecs[14] = '{1'b1, 3'b110, 32'h66000014, 32'h11223344, 32'h0,        32'h66000014, 32'h11223344, 32'h00000000};

      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst = 1'b1; req = 1'b0; we = 1'b0; sz = '0; addr = '0; wdata = '0;
      rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; sz3 = '0; addr3 = '0; wdata3 = '0; rd3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rst3 = 1'b0;
      #1;
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset mem_req", 32'(bus1.mem_req_o), 32'd0);
      chk("reset mem_we", 32'(bus1.mem_we_o), 32'd0);
      chk("reset mem_size", 32'(bus1.mem_size_o), 32'd0);
      chk("reset a_o", bus1.a_o, 32'd0);
      chk("reset wd_o", bus1.wd_o, 32'd0);
      chk("reset rdata", rdata, 32'd0);

      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         run1(v, ns, nr, a_s, wd_s, sz_s, we_s, rd_s, mis_s);
         $display("vec %0d we=%0d sz=%03b addr=%08h stall=%0d a=%08h wd=%08h rdata=%08h",
                  i, v.we, v.sz, v.addr, ns, a_s, wd_s, rd_s);
         chk($sformatf("v%0d stall", i), 32'(ns), 32'd2);
         chk($sformatf("v%0d req_cycles", i), 32'(nr), 32'd1);
         chk($sformatf("v%0d a_o", i), a_s, v.exp_a);
         chk($sformatf("v%0d wd_o", i), wd_s, v.exp_wd);
         chk($sformatf("v%0d mem_size", i), 32'(sz_s), 32'(v.sz));
         chk($sformatf("v%0d mem_we", i), 32'(we_s), 32'(v.we));
         chk($sformatf("v%0d rdata", i), rd_s, v.exp_rdata);
         if (v.we && v.sz == LSU_W) chk($sformatf("v%0d mem word", i), mem[v.addr[5:2]], v.exp_wd);
      end

      // Establish a known result, then a word access at a halfword offset.
      v = '{1'b0, LSU_W, 32'h66000008, 32'h0, 32'hCAFEBABE, 32'h66000008, 32'h0, 32'hCAFEBABE};
      run1(v, ns, nr, a_s, wd_s, sz_s, we_s, rd_s, mis_s);
      chk("lw pre rdata", rd_s, 32'hCAFEBABE);
      v = '{1'b0, LSU_W, 32'h66000002, 32'h0, 32'h13579BDF, 32'h66000000, 32'h0, 32'h13579BDF};
      run1(v, ns, nr, a_s, wd_s, sz_s, we_s, rd_s, mis_s);
      $display("lw misaligned stall=%0d req=%0d rdata=%08h misalign=%0d", ns, nr, rd_s, mis_s);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis stall", 32'(ns), 32'd1);
      chk("mis req_cycles", 32'(nr), 32'd0);
      chk("mis rdata kept", rd_s, 32'hCAFEBABE);
      chk("mis pulse", 32'(mis_s), 32'd1);
      chk("mis pulse end", 32'(mis1), 32'd0);
`else
      chk("lw low bits stall", 32'(ns), 32'd2);
      chk("lw low bits a_o", a_s, 32'h66000000);
      chk("lw low bits rdata", rd_s, 32'h13579BDF);
      chk("lw low bits no trap", 32'(mis_s), 32'd0);
`endif

      // L=3 load: rd_i only valid on the third strobe cycle.
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b0; sz3 = LSU_W; addr3 = 32'h66000020; rd3 = 32'hBAD0BAD0;
      #1;
      ns = 0; nr = 0;
      for (int c = 0; c < 40; c++) begin
         if (!stall3) break;
         ns++;
         if (bus3.mem_req_o) begin
            nr++;
            rd3 = (nr == 3) ? 32'h0F1E2D3C : (32'hBAD00000 | 32'(nr));
         end
         @(posedge clk); #1;
      end
      req3 = 1'b0;
      $display("L3 lw stall=%0d req=%0d rdata=%08h", ns, nr, rdata3);
      chk("L3 stall", 32'(ns), 32'd4);
      chk("L3 req_cycles", 32'(nr), 32'd3);
      chk("L3 rdata", rdata3, 32'h0F1E2D3C);
      @(posedge clk); #1;

      // L=3 store interrupted by reset in its first strobe cycle.
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b1; sz3 = LSU_W; addr3 = 32'h66000024; wdata3 = 32'h00000077;
      @(posedge clk); #1;
      chk("L3 rst pre mem_req", 32'(bus3.mem_req_o), 32'd1);
      chk("L3 rst pre mem_we", 32'(bus3.mem_we_o), 32'd1);
      req3 = 1'b0; rst3 = 1'b1;
      @(posedge clk); #1;
      $display("L3 reset in WAIT mem_req=%0d mem_we=%0d stall=%0d", bus3.mem_req_o, bus3.mem_we_o, stall3);
      chk("L3 rst mem_req", 32'(bus3.mem_req_o), 32'd0);
      chk("L3 rst mem_we", 32'(bus3.mem_we_o), 32'd0);
      chk("L3 rst stall", 32'(stall3), 32'd0);
      chk("L3 rst rdata", rdata3, 32'd0);
      rst3 = 1'b0;

      // Recovery: a byte load after the aborted store.
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b0; sz3 = LSU_B; addr3 = 32'h66000021; rd3 = 32'h24689A57;
      #1;
      ns = 0;
      for (int c = 0; c < 40; c++) begin
         if (!stall3) break;
         ns++;
         @(posedge clk); #1;
      end
      req3 = 1'b0;
      $display("L3 lb after reset stall=%0d rdata=%08h", ns, rdata3);
      chk("L3 recover stall", 32'(ns), 32'd4);
      chk("L3 recover rdata", rdata3, 32'hFFFFFF9A);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench timed out");
   end

endmodule
